// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiplier FSM states, default operand width and
// the total-ALU output select encodings used by the HI/LO consumer.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULTU_WIDTH = 32;

  // Total-ALU output mux select: MFHI reads 01, MFLO reads 10.
  localparam logic [1:0] TSEL_ALU = 2'b00;
  localparam logic [1:0] TSEL_HI  = 2'b01;
  localparam logic [1:0] TSEL_LO  = 2'b10;
  localparam logic [1:0] TSEL_SRL = 2'b11;

endpackage

// File: rtl/multu_seq.sv
// Sequential unsigned WIDTHxWIDTH shift-and-add multiplier for MULTU.
// The fixed-latency result is committed to HI/LO only in the DONE state.
module multu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             multuOp,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (multuOp) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        // Counter hits zero on this edge's update.
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (multuOp) begin
          mcand  <= {{WIDTH{1'b0}}, src_a};
          mplier <= src_b;
          acc    <= '0;
          cnt    <= CW'(WIDTH);
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        DONE: begin
          hi <= acc[2*WIDTH-1:WIDTH];
          lo <= acc[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multu_seq.sv
// Scoreboard bench for multu_seq: stimulus pushes expected {hi,lo}, a
// negedge monitor pops and compares when a result lands after done.
module tb_multu_seq;
  import cpu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         multuOp;
  logic [W-1:0] src_a, src_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  multu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .multuOp(multuOp), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  int unsigned   n_ops = 0;
  int unsigned   done_cnt = 0;
  logic [63:0]   exp_q[$];
  bit            pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: result becomes visible at the edge where done drops.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) pend = 1'b0;
    else if (done) begin
      done_cnt++;
      if (pend) check("done_width", 64'(done), 64'(0));
      pend = 1'b1;
    end else if (pend) begin
      pend = 1'b0;
      check("busy_after_done", 64'(busy), 64'(0));
      if (exp_q.size() == 0) check("unexpected_result", {hi, lo}, 64'hX);
      else begin
        e = exp_q.pop_front();
        check("product", {hi, lo}, e);
      end
    end
  end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    multuOp = 1'b1; src_a = a; src_b = b;
    @(posedge clk); #1;
    multuOp = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] exp);
    exp_q.push_back(exp);
    n_ops++;
    start(a, b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  logic [W-1:0] dir_a[6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0006};
  logic [W-1:0] dir_b[6] = '{32'hDEAD_BEEF, 32'h1, 32'h2, 32'h0001_0000, 32'h2, 32'h0000_0007};
  logic [63:0]  dir_p[6] = '{64'h0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000,
                             64'h0000_0001_0000_0000, 64'h0000_0001_FFFF_FFFE, 64'h0000_0000_0000_002A};

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; multuOp = 1'b0; src_a = '0; src_b = '0;
    #1;
    check("reset_outputs", {busy, done, hi, lo}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 3 x 5 with cycle-exact latency checks
    issue(32'h3, 32'h5, 64'h0000_0000_0000_000F);
    check("busy_after_strobe", 64'(busy), 64'(1));
    repeat (32) begin @(posedge clk); #1; end
    check("done_at_33", {62'b0, busy, done}, 64'h3);
    @(posedge clk); #1;
    check("done_drop_34", {62'b0, busy, done}, 64'h0);
    check("hilo_at_34", {hi, lo}, 64'h0000_0000_0000_000F);

    // All-ones: unsigned, no sign extension
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_idle();
    check("all_ones", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Strobe during RUN is dropped
    issue(32'h7, 32'h9, 64'h0000_0000_0000_003F);
    repeat (4) begin @(posedge clk); #1; end
    multuOp = 1'b1; src_a = 32'hFFFF; src_b = 32'hFFFF;
    @(posedge clk); #1;
    multuOp = 1'b0;
    wait_idle();
    check("ignored_strobe", {hi, lo}, 64'h3F);
    repeat (2) begin @(posedge clk); #1; end
    check("no_queued_run", 64'(busy), 64'(0));

    // Async reset at RUN cycle 10 aborts and clears HI/LO
    start(32'h1234, 32'h10);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_reset", {busy, done, hi, lo}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    issue(32'h10, 32'h10, 64'h100);
    wait_idle();
    check("after_abort", {hi, lo}, 64'h100);

    // Directed edge vectors, each issued on the first IDLE cycle
    for (int i = 0; i < 6; i++) begin
      issue(dir_a[i], dir_b[i], dir_p[i]);
      wait_idle();
    end

    // Back-to-back random operand pairs
    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom;
      issue(ra, rb, 64'(ra) * 64'(rb));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(n_ops));
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
